seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
- Sits directly upstream of the digit selector / 7-seg decoder stage and drives its digit0..digit3 and sel inputs.
- Also drives the active-low anode enables.
- Holds a frame-synchronous shadow of the displayed value, so updates never tear mid-scan.
- Provides leading-zero blanking and an anode-off guard interval at every digit change to suppress ghosting.

Parameters:
- DIV, 100000: clock cycles per digit slot; legal range >= 4.
- GUARD, 2: cycles all anodes are forced off at the start of each slot; legal range 0 <= GUARD < DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = scanning runs; 0 = prescaler and sel frozen, all anodes off
- load  in  1  single-cycle strobe; capture value into the pending register
- value  in  16  four hex nibbles; [3:0] is digit0 (rightmost), [15:12] is digit3
- blank_lz  in  1  1 = blank leading zero digits
- digit0, digit1, digit2, digit3  out  4 each  displayed nibbles, to the decoder stage
- sel  out  2  current digit slot, to the decoder stage
- an  out  4  anode enables, active-low; an[k] lights digit k
- busy  out  1  1 = pending value not yet transferred to the display

Behaviour:
- Reset is asynchronous on rst_n low. Reset values:
  - prescaler = 0, sel = 0
  - digit0..3 = 0, pending = 0, busy = 0
  - guard counter = GUARD, so an = 4'b1111 for the first GUARD enabled cycles after reset release
- Prescaler:
  - Counts 0..DIV-1 while enable = 1, width $clog2(DIV).
  - tick = enable && (prescaler == DIV-1).
  - On tick, prescaler wraps to 0.
- Scan:
  - On tick, sel <= sel + 1 mod 4; 3 wraps to 0.
  - On tick, the guard counter reloads with GUARD.
  - Otherwise, while enable = 1 and the guard counter is nonzero, it decrements.
- Shadow update:
  - load = 1 captures value into pending and sets busy.
  - A frame boundary is a tick with sel == 3.
  - At a frame boundary with busy = 1: digit0..3 <= pending, busy <= 0.
  - load on the same cycle as a frame boundary: value goes straight to digit0..3 and busy stays 0.
  - load on the cycle after a frame boundary waits a full frame (4*DIV cycles).
  - Repeated loads before transfer: the last one wins.
  - load is accepted while enable = 0; transfer waits until scanning resumes.
- Leading-zero blanking, active only when blank_lz = 1:
  - digit3 is blanked if digit3 == 0.
  - digit2 is blanked if digit3 and digit2 are both 0.
  - digit1 is blanked if digit3, digit2 and digit1 are all 0.
  - digit0 is never blanked.
  - Blanking affects an only; the digit outputs keep their true values.
- Anode output is combinational from registered state:
  - an[k] = 0 only if enable = 1, sel == k, guard counter == 0, and digit k is not blanked.
  - In all other cases an[k] = 1; at most one bit of an is low.
- With GUARD = 0, an switches in the same cycle as sel; there is no dead time.
- enable falling:
  - an goes to 4'b1111 immediately.
  - prescaler, sel and guard counter hold their values.
  - Scanning resumes from the held state when enable returns high.
- Reset asserted mid-frame: all state returns to reset values asynchronously, and pending data is discarded.

Test Plan:
- Reset and guard (DIV=8, GUARD=2, enable=1): release rst_n -> an = 1111 for 2 cycles, then 1110; sel = 0 for 8 cycles total, then 1, with an = 1111 for 2 more cycles, then 1101.
- Scan sequence: run 32 cycles -> sel steps 0, 1, 2, 3, 0 every 8 cycles; an low-bit pattern cycles 1110, 1101, 1011, 0111; never more than one bit low.
- Frame-synchronous load: load value = 16'h1234 while sel = 1 -> busy = 1 and digits unchanged until the tick with sel == 3. Then digit3..0 = 1, 2, 3, 4 and busy = 0.
- Coincident load: assert load with 16'hABCD on the frame-boundary cycle -> digits = A, B, C, D on the next cycle, busy never asserts. A second load of 16'h5678 mid-frame, followed by 16'h9999 before the boundary, transfers 16'h9999.
- Leading-zero blanking: digits 16'h0070 with blank_lz = 1 -> an[3] and an[2] stay 1 in their slots, digit1 and digit0 light. 16'h0000 -> only digit0 lights. blank_lz = 0 -> all four digits light.
- Enable and reset mid-scan: drop enable at sel = 2, prescaler = 5 -> an = 1111, sel = 2 held for 20 cycles. Re-enable -> the next tick arrives after 2 more cycles. Pulse rst_n low mid-frame -> all outputs return to reset values at once, with pending 16'h4321 lost.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display: frame-synchronous
// shadow of the shown value, leading-zero blanking and an anode-off guard per slot.
module seg7_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int GUARD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [1:0]  sel,
  output logic [3:0]  an,
  output logic        busy
);

  localparam int            PW     = $clog2(DIV);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] G_INIT = PW'(GUARD);

  logic [PW-1:0] r_presc;
  logic [PW-1:0] r_guard;
  logic [1:0]    r_sel;
  logic [15:0]   r_pend;
  logic [15:0]   r_digits;
  logic          r_busy;

  logic          w_tick;
  logic          w_frame;
  logic [3:0]    w_blank;

  assign w_tick  = enable && (r_presc == P_LAST);
  assign w_frame = w_tick && (r_sel == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_sel   <= 2'd0;
      r_guard <= G_INIT;
    end else if (w_tick) begin
      r_presc <= '0;
      r_sel   <= r_sel + 2'd1;
      r_guard <= G_INIT;
    end else if (enable) begin
      r_presc <= r_presc + 1'b1;
      if (r_guard != '0) r_guard <= r_guard - 1'b1;
    end
  end

  // A load coinciding with the frame boundary bypasses the pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= '0;
      r_digits <= '0;
      r_busy   <= 1'b0;
    end else if (w_frame) begin
      if (load) r_digits <= value;
      else if (r_busy) r_digits <= r_pend;
      r_busy <= 1'b0;
    end else if (load) begin
      r_pend <= value;
      r_busy <= 1'b1;
    end
  end

  assign w_blank[3] = blank_lz && (r_digits[15:12] == 4'h0);
  assign w_blank[2] = w_blank[3] && (r_digits[11:8] == 4'h0);
  assign w_blank[1] = w_blank[2] && (r_digits[7:4] == 4'h0);
  assign w_blank[0] = 1'b0;

  always_comb begin
    an = 4'b1111;
    if (enable && (r_guard == '0) && !w_blank[r_sel]) an[r_sel] = 1'b0;
  end

  assign digit0 = r_digits[3:0];
  assign digit1 = r_digits[7:4];
  assign digit2 = r_digits[11:8];
  assign digit3 = r_digits[15:12];
  assign sel    = r_sel;
  assign busy   = r_busy;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (DIV=8, GUARD=2): per-cycle expectations are queued
// as stimulus is driven and compared when the DUT state is sampled.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  digit0, digit1, digit2, digit3;
  logic [1:0]  sel;
  logic [3:0]  an;
  logic        busy;
  logic [15:0] dig_act;

  assign dig_act = {digit3, digit2, digit1, digit0};

  seg7_scan_ctrl #(.DIV(8), .GUARD(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .blank_lz(blank_lz), .digit0(digit0), .digit1(digit1), .digit2(digit2),
    .digit3(digit3), .sel(sel), .an(an), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  an;
    logic [1:0]  sel;
    logic        busy;
    logic [15:0] dig;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          t;
  logic [15:0] m_dig, m_pend;
  logic        m_busy;

  // t counts enabled cycles since reset: slot = (t/8)%4, guard covers t%8 < 2.
  function automatic logic [3:0] model_an(input int tt, input logic [15:0] d,
                                          input logic en, input logic blz);
    logic [1:0] slot;
    logic [3:0] bl;
    logic [3:0] one;
    one   = 4'b0001;
    slot  = 2'((tt / 8) % 4);
    bl[3] = blz && (d[15:12] == 4'h0);
    bl[2] = bl[3] && (d[11:8] == 4'h0);
    bl[1] = bl[2] && (d[7:4] == 4'h0);
    bl[0] = 1'b0;
    if (!en || (tt % 8) < 2 || bl[slot]) return 4'b1111;
    return ~(one << slot);
  endfunction

  task automatic model_reset();
    t = 0; m_dig = '0; m_pend = '0; m_busy = 1'b0;
  endtask

  task automatic drive(input logic ld, input logic [15:0] val, input logic en, input logic blz);
    exp_t e;
    load = ld; value = val; enable = en; blank_lz = blz;
    e.an = model_an(t, m_dig, en, blz);
    e.sel = 2'((t / 8) % 4);
    e.busy = m_busy;
    e.dig = m_dig;
    exp_q.push_back(e);
    if (en && (t % 32) == 31) begin
      if (ld) m_dig = val;
      else if (m_busy) m_dig = m_pend;
      m_busy = 1'b0;
    end else if (ld) begin
      m_pend = val;
      m_busy = 1'b1;
    end
    if (en) t++;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; enable = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (an !== 4'hF || sel !== 2'd0 || busy !== 1'b0 || dig_act !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state got an=%b sel=%0d busy=%b dig=%h, want 1111/0/0/0000", an, sel, busy, dig_act);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      @(negedge clk); e = exp_q.pop_front(); n_chk++;
      if (an !== e.an || sel !== e.sel || busy !== e.busy || dig_act !== e.dig) begin
        n_fail++;
        $display("FAIL reset_guard t=%0d got an=%b sel=%0d busy=%b dig=%h, want an=%b sel=%0d busy=%b dig=%h",
                 t, an, sel, busy, dig_act, e.an, e.sel, e.busy, e.dig);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_scan();
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      @(negedge clk); e = exp_q.pop_front(); n_chk += 2;
      if (an !== e.an || sel !== e.sel || busy !== e.busy || dig_act !== e.dig) begin
        n_fail++;
        $display("FAIL scan t=%0d got an=%b sel=%0d busy=%b dig=%h, want an=%b sel=%0d busy=%b dig=%h",
                 t, an, sel, busy, dig_act, e.an, e.sel, e.busy, e.dig);
      end
      if ($countones(~an) > 1) begin
        n_fail++;
        $display("FAIL scan_onehot t=%0d got an=%b, want at most one low bit", t, an);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_frame_load();
    exp_t e;
    for (int i = 0; i < 54; i++) begin
      drive((t % 32) == 10 && i < 32, 16'h1234, 1'b1, 1'b0);
      @(negedge clk); e = exp_q.pop_front(); n_chk++;
      if (an !== e.an || sel !== e.sel || busy !== e.busy || dig_act !== e.dig) begin
        n_fail++;
        $display("FAIL frame_load t=%0d got an=%b sel=%0d busy=%b dig=%h, want an=%b sel=%0d busy=%b dig=%h",
                 t, an, sel, busy, dig_act, e.an, e.sel, e.busy, e.dig);
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (dig_act !== 16'h1234 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_load_final got dig=%h busy=%b, want 1234/0", dig_act, busy);
    end
  endtask

  task automatic test_coincident();
    exp_t e;
    int f;
    logic ld;
    logic [15:0] v;
    f = t - (t % 32) + 31;
    while (t <= f + 35) begin
      ld = 1'b1;
      if (t == f) v = 16'hABCD;
      else if (t == f + 9) v = 16'h5678;
      else if (t == f + 21) v = 16'h9999;
      else begin ld = 1'b0; v = 16'h0; end
      drive(ld, v, 1'b1, 1'b0);
      @(negedge clk); e = exp_q.pop_front(); n_chk++;
      if (an !== e.an || sel !== e.sel || busy !== e.busy || dig_act !== e.dig) begin
        n_fail++;
        $display("FAIL coincident t=%0d got an=%b sel=%0d busy=%b dig=%h, want an=%b sel=%0d busy=%b dig=%h",
                 t, an, sel, busy, dig_act, e.an, e.sel, e.busy, e.dig);
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (dig_act !== 16'h9999 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL coincident_final got dig=%h busy=%b, want 9999/0", dig_act, busy);
    end
  endtask

  task automatic test_blanking();
    exp_t e;
    int f, ph;
    int lit[3][4];
    int want[3][4];
    want = '{'{6, 6, 0, 0}, '{6, 0, 0, 0}, '{6, 6, 6, 6}};
    for (int p = 0; p < 3; p++) for (int k = 0; k < 4; k++) lit[p][k] = 0;
    f = t - (t % 32) + 31;
    while (t <= f + 96) begin
      ph = (t - f - 1) / 32;
      drive(t == f || t == f + 32, (t == f) ? 16'h0070 : 16'h0000, 1'b1, t <= f + 64);
      @(negedge clk); e = exp_q.pop_front(); n_chk++;
      if (an !== e.an || sel !== e.sel || busy !== e.busy || dig_act !== e.dig) begin
        n_fail++;
        $display("FAIL blanking t=%0d got an=%b sel=%0d busy=%b dig=%h, want an=%b sel=%0d busy=%b dig=%h",
                 t, an, sel, busy, dig_act, e.an, e.sel, e.busy, e.dig);
      end
      if (t > f + 1)
        for (int k = 0; k < 4; k++) if (an[k] === 1'b0) lit[ph][k]++;
      @(posedge clk); #1;
    end
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (lit[p][k] != want[p][k]) begin
          n_fail++;
          $display("FAIL blank_count phase=%0d digit=%0d got %0d lit cycles, want %0d", p, k, lit[p][k], want[p][k]);
        end
      end
  endtask

  task automatic test_enable();
    exp_t e;
    int j;
    while ((t % 32) != 21) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      @(negedge clk); e = exp_q.pop_front(); n_chk++;
      if (an !== e.an || sel !== e.sel || busy !== e.busy || dig_act !== e.dig) begin
        n_fail++;
        $display("FAIL enable_pre t=%0d got an=%b sel=%0d busy=%b dig=%h, want an=%b sel=%0d busy=%b dig=%h",
                 t, an, sel, busy, dig_act, e.an, e.sel, e.busy, e.dig);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20; i++) begin
      drive(i == 5, 16'h00F1, 1'b0, 1'b0);
      @(negedge clk); e = exp_q.pop_front(); n_chk++;
      if (an !== 4'hF || sel !== 2'd2 || busy !== e.busy || dig_act !== e.dig) begin
        n_fail++;
        $display("FAIL enable_hold i=%0d got an=%b sel=%0d busy=%b dig=%h, want an=1111 sel=2 busy=%b dig=%h",
                 i, an, sel, busy, dig_act, e.busy, e.dig);
      end
      @(posedge clk); #1;
    end
    j = 0;
    while ((t % 32) != 2) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      @(negedge clk); e = exp_q.pop_front(); n_chk++;
      if (an !== e.an || sel !== e.sel || busy !== e.busy || dig_act !== e.dig) begin
        n_fail++;
        $display("FAIL enable_resume t=%0d got an=%b sel=%0d busy=%b dig=%h, want an=%b sel=%0d busy=%b dig=%h",
                 t, an, sel, busy, dig_act, e.an, e.sel, e.busy, e.dig);
      end
      if (j == 2 || j == 3) begin
        n_chk++;
        if (sel !== ((j == 2) ? 2'd2 : 2'd3)) begin
          n_fail++;
          $display("FAIL enable_tick j=%0d got sel=%0d, want %0d", j, sel, (j == 2) ? 2 : 3);
        end
      end
      j++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (dig_act !== 16'h00F1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_load got dig=%h busy=%b, want 00f1/0", dig_act, busy);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    while ((t % 32) != 13) begin
      drive((t % 32) == 8, 16'h4321, 1'b1, 1'b0);
      @(negedge clk); e = exp_q.pop_front(); n_chk++;
      if (an !== e.an || sel !== e.sel || busy !== e.busy || dig_act !== e.dig) begin
        n_fail++;
        $display("FAIL reset_mid_pre t=%0d got an=%b sel=%0d busy=%b dig=%h, want an=%b sel=%0d busy=%b dig=%h",
                 t, an, sel, busy, dig_act, e.an, e.sel, e.busy, e.dig);
      end
      @(posedge clk); #1;
    end
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (an !== 4'hF || sel !== 2'd0 || busy !== 1'b0 || dig_act !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async got an=%b sel=%0d busy=%b dig=%h, want 1111/0/0/0000", an, sel, busy, dig_act);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      @(negedge clk); e = exp_q.pop_front(); n_chk++;
      if (an !== e.an || sel !== e.sel || busy !== e.busy || dig_act !== e.dig) begin
        n_fail++;
        $display("FAIL reset_mid_after t=%0d got an=%b sel=%0d busy=%b dig=%h, want an=%b sel=%0d busy=%b dig=%h",
                 t, an, sel, busy, dig_act, e.an, e.sel, e.busy, e.dig);
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (dig_act !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_pending got dig=%h, want 0000", dig_act);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_scan();
    test_frame_load();
    test_coincident();
    test_blanking();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
